// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, combinational I-mem port and the IF/ID register.
// Handles hazard stalls, branch/jump redirects and flushes so decode sees a valid word or a NOP.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        flush,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'h3;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_squash;
  logic        w_load;
  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [31:0] w_pc_plus4_next;
  logic        w_valid_next;
  logic [31:0] w_count_next;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = redirect_target & ~32'h3;

  // A redirect only counts when not stalled; the ID stage re-presents it after the stall.
  assign w_squash = flush | (redirect & ~stall);
  assign w_load   = ~w_squash & ~stall;

  always_comb begin
    w_pc_next = r_pc;
    if (!stall) begin
      if (redirect) begin
        w_pc_next = w_target;
      end else begin
        w_pc_next = w_pc_plus4;
      end
    end
  end

  always_comb begin
    w_instr_next    = r_instr;
    w_pc_plus4_next = r_pc_plus4;
    w_valid_next    = r_valid;
    w_count_next    = r_count;
    if (w_squash) begin
      w_instr_next    = NOP_INSTR;
      w_pc_plus4_next = w_pc_plus4;
      w_valid_next    = 1'b0;
    end else if (w_load) begin
      w_instr_next    = imem_data;
      w_pc_plus4_next = w_pc_plus4;
      w_valid_next    = 1'b1;
      w_count_next    = r_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= ResetPcAligned;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
      r_count    <= 32'h0000_0000;
    end else begin
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_pc_plus4 <= w_pc_plus4_next;
      r_valid    <= w_valid_next;
      r_count    <= w_count_next;
    end
  end

  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus4 = r_pc_plus4;
  assign if_id_valid    = r_valid;
  assign fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control traffic
// compared against a behavioural pipeline model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        stall, redirect, flush;
  logic [31:0] redirect_target;
  logic [31:0] pc, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid;

  logic        rst2_n;
  logic [31:0] imem_addr2, imem_data2, pc2, instr2, pc4_2, count2;
  logic        valid2;

  logic [31:0] mem [64];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  assign imem_data  = mem[imem_addr[7:2]];
  assign imem_data2 = mem[imem_addr2[7:2]];

  fetch_stage u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .flush           (flush),
    .pc              (pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) u_wrap (
    .clk             (clk),
    .rst_n           (rst2_n),
    .imem_addr       (imem_addr2),
    .imem_data       (imem_data2),
    .stall           (1'b0),
    .redirect        (1'b0),
    .redirect_target (32'h0000_0000),
    .flush           (1'b0),
    .pc              (pc2),
    .if_id_instr     (instr2),
    .if_id_pc_plus4  (pc4_2),
    .if_id_valid     (valid2),
    .fetch_count     (count2)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
  endtask

  // One clock of the pipeline as described by the fetch rules.
  task automatic model_edge(input logic s, input logic r, input logic [31:0] t, input logic f);
    logic [31:0] seq;
    logic [31:0] word;
    seq  = m_pc + 32'd4;
    word = mem[m_pc[7:2]];
    if (f || (r && !s)) begin
      m_instr = 32'h0; m_valid = 1'b0; m_pc4 = seq;
    end else if (!s) begin
      m_instr = word; m_valid = 1'b1; m_pc4 = seq; m_cnt = m_cnt + 1;
    end
    if (!s) m_pc = r ? {t[31:2], 2'b00} : seq;
  endtask

  task automatic cycle(input logic s, input logic r, input logic [31:0] t, input logic f);
    stall = s; redirect = r; redirect_target = t; flush = f;
    model_edge(s, r, t, f);
    @(posedge clk);
    #1;
    stall = 1'b0; redirect = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; flush = 1'b0; redirect_target = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0212_8020;
    mem[1] = 32'h0212_9022;
    mem[2] = 32'h0272_9820;
    mem[4] = 32'h1234_5678;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks += 5;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
    if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=0", if_id_pc_plus4); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h0212_8020; exp_w[1] = 32'h0212_9022; exp_w[2] = 32'h0272_9820;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n_checks += 5;
      if (if_id_instr !== exp_w[i]) begin n_fail++; $display("FAIL seq_instr%0d got=%h exp=%h", i, if_id_instr, exp_w[i]); end
      if (if_id_pc_plus4 !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_pc4_%0d got=%h exp=%0d", i, if_id_pc_plus4, 4 * (i + 1)); end
      if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d got=%b exp=1", i, if_id_valid); end
      if (fetch_count !== 32'(i + 1)) begin n_fail++; $display("FAIL seq_count%0d got=%0d exp=%0d", i, fetch_count, i + 1); end
      if (imem_addr !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_addr%0d got=%h exp=%0d", i, imem_addr, 4 * (i + 1)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      n_checks += 3;
      if (pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc%0d got=%h exp=8", k, pc); end
      if (if_id_instr !== 32'h0212_9022) begin n_fail++; $display("FAIL stall_instr%0d got=%h exp=02129022", k, if_id_instr); end
      if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count%0d got=%0d exp=2", k, fetch_count); end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks += 3;
    if (if_id_instr !== 32'h0272_9820) begin n_fail++; $display("FAIL stall_resume got=%h exp=02729820", if_id_instr); end
    if (pc !== 32'hC) begin n_fail++; $display("FAIL stall_resume_pc got=%h exp=c", pc); end
    if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL stall_resume_count got=%0d exp=3", fetch_count); end
  endtask

  task automatic test_redirect();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0013, 1'b0);
    n_checks += 4;
    if (pc !== 32'h10) begin n_fail++; $display("FAIL redir_pc got=%h exp=10", pc); end
    if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL redir_nop got=%h exp=0", if_id_instr); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got=%b exp=0", if_id_valid); end
    if (if_id_pc_plus4 !== 32'hC) begin n_fail++; $display("FAIL redir_pc4 got=%h exp=c", if_id_pc_plus4); end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks += 3;
    if (if_id_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL redir_target_instr got=%h exp=12345678", if_id_instr); end
    if (if_id_pc_plus4 !== 32'h14) begin n_fail++; $display("FAIL redir_target_pc4 got=%h exp=14", if_id_pc_plus4); end
    if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL redir_count got=%0d exp=3", fetch_count); end
  endtask

  task automatic test_stall_combos();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    n_checks += 3;
    if (pc !== 32'h8) begin n_fail++; $display("FAIL redir_stall_pc got=%h exp=8", pc); end
    if (if_id_instr !== 32'h0212_9022) begin n_fail++; $display("FAIL redir_stall_instr got=%h exp=02129022", if_id_instr); end
    if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_stall_valid got=%b exp=1", if_id_valid); end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks += 4;
    if (pc !== 32'h8) begin n_fail++; $display("FAIL flush_stall_pc got=%h exp=8", pc); end
    if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL flush_stall_instr got=%h exp=0", if_id_instr); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall_valid got=%b exp=0", if_id_valid); end
    if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL flush_stall_count got=%0d exp=2", fetch_count); end
  endtask

  task automatic test_random();
    logic        s, r, f;
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 99) < 25);
      r = ($urandom_range(0, 99) < 15);
      f = ($urandom_range(0, 99) < 10);
      t = $urandom_range(0, 255);
      cycle(s, r, t, f);
      n_checks += 6;
      if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, pc, m_pc); end
      if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, imem_addr, m_pc); end
      if (if_id_instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, if_id_instr, m_instr); end
      if (if_id_pc_plus4 !== m_pc4) begin n_fail++; $display("FAIL rnd_pc4 i=%0d got=%h exp=%h", i, if_id_pc_plus4, m_pc4); end
      if (if_id_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, if_id_valid, m_valid); end
      if (fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, fetch_count, m_cnt); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL async_pc got=%h exp=0", pc); end
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL async_addr got=%h exp=0", imem_addr); end
    if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL async_instr got=%h exp=0", if_id_instr); end
    if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL async_pc4 got=%h exp=0", if_id_pc_plus4); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", if_id_valid); end
    if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL async_count got=%0d exp=0", fetch_count); end
    do_reset();
  endtask

  task automatic test_wrap();
    rst2_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks += 1;
    if (pc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_reset_pc got=%h exp=fffffffc", pc2); end
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 4;
    if (pc2 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=0", pc2); end
    if (pc4_2 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=0", pc4_2); end
    if (instr2 !== mem[63]) begin n_fail++; $display("FAIL wrap_instr got=%h exp=%h", instr2, mem[63]); end
    if (valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got=%b exp=1", valid2); end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; flush = 1'b0; redirect_target = 32'h0;
    load_program();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_combos();
    test_async_reset();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter and drives the instruction memory's word-addressed read port, which is combinational. Latches the returned word into the IF/ID pipeline register together with PC+4. Applies hazard-unit stalls, branch/jump redirects and flushes so the decode stage always sees either a valid instruction or a NOP bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- NOP_INSTR, 32'h0000_0000, encoding written into IF/ID for a bubble (sll $0,$0,0)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte address to instruction memory read port; always equals pc
- imem_data  in  32  instruction word from memory, valid in the same cycle as imem_addr
- stall  in  1  hazard unit: hold PC and IF/ID contents
- redirect  in  1  ID stage: branch taken or jump; load redirect_target into PC
- redirect_target  in  32  byte target address; bits [1:0] ignored (forced 0)
- flush  in  1  force a bubble into IF/ID on this edge
- pc  out  32  current fetch PC
- if_id_instr  out  32  latched instruction
- if_id_pc_plus4  out  32  latched PC+4 of that instruction
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction, 0 = bubble
- fetch_count  out  32  number of instructions latched with valid=1 since reset

## Operation
- The clock is clk. Reset is rst_n, which is asynchronous and active-low.
- Combinational: imem_addr = pc. pc_plus4 = pc + 32'd4, truncated to 32 bits, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Next-PC priority, evaluated at each rising edge:
  - stall=1: pc holds; redirect is ignored. The ID stage re-presents redirect once the stall clears.
  - else redirect=1: pc ← {redirect_target[31:2], 2'b00}
  - else: pc ← pc_plus4
- IF/ID priority:
  - flush=1, or redirect=1 with stall=0: instr ← NOP_INSTR, valid ← 0, pc_plus4 ← pc_plus4. The wrong-path fetch is squashed, giving a one-cycle redirect penalty.
  - else stall=1: all IF/ID fields hold.
  - else: instr ← imem_data, pc_plus4 ← pc_plus4, valid ← 1.
- flush=1 together with stall=1: IF/ID takes a bubble (flush wins) and pc holds (stall wins).
- fetch_count increments by 1 on every edge where IF/ID loads with valid ← 1. It wraps modulo 2^32.
- No internal state beyond pc, the IF/ID register and fetch_count.

## Timing
- Reset, asynchronous, effective immediately on rst_n=0:
  - pc = RESET_PC
  - if_id_instr = NOP_INSTR
  - if_id_pc_plus4 = 0
  - if_id_valid = 0
  - fetch_count = 0
- While rst_n=0, the pipeline stays in reset. A reset asserted mid-operation discards the in-flight IF/ID contents and any pending redirect.
- First edge after rst_n rises, with no stall/flush/redirect:
  - if_id_instr = IM[RESET_PC>>2]
  - if_id_valid = 1
  - pc = RESET_PC+4
- Fetch latency is one cycle: an instruction at address A appears on if_id_instr the edge after pc=A.
- Redirect latency: if redirect is sampled at edge n, pc = target after edge n and the target instruction is in IF/ID after edge n+1.
- Stall is level-sensitive. Holding it for k cycles freezes pc and IF/ID for k edges with no lost or duplicated instruction.
- All outputs are registered except imem_addr, which is a wire copy of pc.

## Test plan
- Reset and sequential fetch:
  - Memory holds 0x02128020, 0x02129022, 0x02729820 at words 0..2.
  - Release rst_n.
  - IF/ID shows these words on successive edges with pc_plus4 = 4, 8, 12; valid=1; fetch_count = 1, 2, 3.
- Stall:
  - Assert stall for 2 cycles while pc=8.
  - pc stays 8; if_id_instr stays 0x02129022; fetch_count is unchanged.
  - Next edge loads 0x02729820.
- Redirect:
  - At pc=8, assert redirect with target 0x0000_0013.
  - pc becomes 0x10; IF/ID = NOP with valid=0.
  - Next edge: IF/ID = IM[4], pc_plus4=0x14.
- Redirect during stall, and flush during stall:
  - redirect=1 with stall=1: pc holds; IF/ID holds.
  - flush=1 with stall=1: pc holds; IF/ID = NOP with valid=0.
- Asynchronous reset mid-run:
  - Drop rst_n between edges.
  - All outputs return to their reset values immediately, without waiting for an edge.
- Wrap-around:
  - Use RESET_PC=0xFFFF_FFFC.
  - After the first edge, pc=0 and if_id_pc_plus4=0.
